// File: rtl/demux_scan_pkg.sv
// ============================================================================
// Module      : demux_scan_pkg
// Description : Mode and direction encodings shared by the demux_scan block.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package demux_scan_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'b00,
        MODE_SCAN_UP   = 2'b01,
        MODE_SCAN_DOWN = 2'b10,
        MODE_BOUNCE    = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

`default_nettype wire

// File: rtl/demux_scan_tick_gen.sv
// ============================================================================
// Module      : tick_gen
// Description : Programmable prescaler counting 0..div; emits a step strobe
//               and a registered tick aligned with the resulting index update.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             hold,
    input  logic [DIV_W-1:0] div,
    output logic             step,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        step   = 1'b0;
        cnt_d  = cnt_q;
        // Clear wins over hold so a mode change while disabled still restarts the period.
        if (clear) begin
            cnt_d = '0;
        end else if (!hold) begin
            if (cnt_q == div) begin
                step  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
        tick_d = step;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/demux_scan.sv
// ============================================================================
// Module      : demux_scan
// Description : One-hot demultiplexer with direct select and up/down/bounce
//               scanning driven by a programmable prescaler.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module demux_scan
    import demux_scan_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DIV_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [DIV_W-1:0]    div,
    output logic [2**SEL_W-1:0] y,
    output logic [SEL_W-1:0]    idx,
    output logic                tick
);

    localparam int               N       = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] IDX_ONE = SEL_W'(1);
    localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(N - 1);
    localparam logic [N-1:0]     Y_ONE   = N'(1);

    mode_e            mode_in;
    mode_e            mode_q, mode_d;
    dir_e             dir_q, dir_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [N-1:0]     y_q, y_d;
    logic             mode_changed;
    logic             step;

    assign mode_in      = mode_e'(mode);
    assign mode_changed = (mode_in != mode_q);

    tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (mode_changed || (mode_in == MODE_DIRECT)),
        .hold  (!en),
        .div   (div),
        .step  (step),
        .tick  (tick)
    );

    always_comb begin
        mode_d = mode_in;
        dir_d  = dir_q;
        idx_d  = idx_q;
        if (en) begin
            if (mode_changed && (mode_in == MODE_SCAN_UP))   dir_d = DIR_UP;
            if (mode_changed && (mode_in == MODE_SCAN_DOWN)) dir_d = DIR_DOWN;
            case (mode_in)
                MODE_DIRECT: idx_d = sel;
                MODE_SCAN_UP: begin
                    if (step) idx_d = idx_q + IDX_ONE;
                end
                MODE_SCAN_DOWN: begin
                    if (step) idx_d = idx_q - IDX_ONE;
                end
                MODE_BOUNCE: begin
                    // End points reverse direction and move inward in the same step.
                    if (step) begin
                        if (dir_q == DIR_UP) begin
                            if (idx_q == IDX_MAX) begin
                                dir_d = DIR_DOWN;
                                idx_d = idx_q - IDX_ONE;
                            end else begin
                                idx_d = idx_q + IDX_ONE;
                            end
                        end else begin
                            if (idx_q == '0) begin
                                dir_d = DIR_UP;
                                idx_d = idx_q + IDX_ONE;
                            end else begin
                                idx_d = idx_q - IDX_ONE;
                            end
                        end
                    end
                end
                default: idx_d = idx_q;
            endcase
        end
        y_d = en ? (Y_ONE << idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= MODE_DIRECT;
            dir_q  <= DIR_UP;
            idx_q  <= '0;
            y_q    <= '0;
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
            idx_q  <= idx_d;
            y_q    <= y_d;
        end
    end

    assign y   = y_q;
    assign idx = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_demux_scan.sv
// ============================================================================
// Module      : tb_demux_scan
// Description : Directed table plus randomized run against a sweep-phase model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_demux_scan;

    localparam int SEL_W = 3;
    localparam int DIV_W = 4;
    localparam int N     = 2 ** SEL_W;
    localparam int PER   = 2 * N - 2;

    localparam logic [1:0] D  = 2'b00;
    localparam logic [1:0] SU = 2'b01;
    localparam logic [1:0] SD = 2'b10;
    localparam logic [1:0] B  = 2'b11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [1:0]       mode;
    logic [SEL_W-1:0] sel;
    logic [DIV_W-1:0] div;
    logic [N-1:0]     y;
    logic [SEL_W-1:0] idx;
    logic             tick;

    demux_scan #(
        .SEL_W (SEL_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .div   (div),
        .y     (y),
        .idx   (idx),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst_n;
        logic             en;
        logic [1:0]       mode;
        logic [SEL_W-1:0] sel;
        logic [DIV_W-1:0] div;
        logic [N-1:0]     y;
        logic [SEL_W-1:0] idx;
        logic             tick;
    } vec_t;

    vec_t tbl[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference state: bounce position is tracked as a phase around a 2N-2 cycle.
    int m_idx, m_cnt, m_prev;
    bit m_up, m_en, m_tick;

    task automatic add(input logic r, input logic e, input logic [1:0] m,
                       input logic [SEL_W-1:0] s, input logic [DIV_W-1:0] dv,
                       input logic [N-1:0] ey, input logic [SEL_W-1:0] ei, input logic et);
        vec_t v;
        v.rst_n = r; v.en = e; v.mode = m; v.sel = s; v.div = dv;
        v.y = ey; v.idx = ei; v.tick = et;
        tbl.push_back(v);
    endtask

    task automatic model_step(input bit r, input bit e, input int m, input int s, input int dv);
        bit changed;
        int p;
        if (!r) begin
            m_idx = 0; m_cnt = 0; m_up = 1; m_en = 0; m_tick = 0; m_prev = 0;
            return;
        end
        changed = (m != m_prev);
        m_prev  = m;
        m_en    = e;
        m_tick  = 0;
        if (changed || m == 0) m_cnt = 0;
        if (e) begin
            if (changed && m == 1) m_up = 1;
            if (changed && m == 2) m_up = 0;
            if (m == 0) begin
                m_idx = s;
            end else if (!changed) begin
                if (m_cnt == dv) begin
                    m_cnt  = 0;
                    m_tick = 1;
                    if (m == 1) m_idx = (m_idx + 1) % N;
                    else if (m == 2) m_idx = (m_idx + N - 1) % N;
                    else begin
                        p     = m_up ? m_idx : (PER - m_idx) % PER;
                        p     = (p + 1) % PER;
                        m_idx = (p < N) ? p : PER - p;
                        m_up  = (p >= 1) && (p <= N - 1);
                    end
                end else begin
                    m_cnt = (m_cnt + 1) % (2 ** DIV_W);
                end
            end
        end
    endtask

    task automatic apply(input logic r, input logic e, input logic [1:0] m,
                         input logic [SEL_W-1:0] s, input logic [DIV_W-1:0] dv);
        rst_n = r; en = e; mode = m; sel = s; div = dv;
        @(posedge clk);
        model_step(r, e, int'(m), int'(s), int'(dv));
        #1;
    endtask

    task automatic check(input string nm, input logic [N-1:0] ey,
                         input logic [SEL_W-1:0] ei, input logic et);
        vectors++;
        if (y !== ey || idx !== ei || tick !== et) begin
            miscompares++;
            $display("FAIL %s: got y=%h idx=%0d tick=%0b, want y=%h idx=%0d tick=%0b",
                     nm, y, idx, tick, ey, ei, et);
        end
    endtask

    initial begin
        logic [SEL_W-1:0] bidx [15];
        logic [N-1:0]     bys  [15];
        logic [1:0]       rmode;
        logic [DIV_W-1:0] rdiv;

        rst_n = 1'b0; en = 1'b0; mode = D; sel = '0; div = '0;

        // Reset, then direct decode of 5 and 0
        add(0, 0, D, 0, 0, 8'h00, 0, 0);
        add(1, 1, D, 5, 0, 8'h20, 5, 0);
        add(1, 1, D, 0, 0, 8'h01, 0, 0);
        // Bounce at div=0: entry cycle only restarts the prescaler
        add(1, 1, B, 0, 0, 8'h01, 0, 0);
        bidx = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        bys  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        for (int i = 0; i < 15; i++) add(1, 1, B, 0, 0, bys[i], bidx[i], 1);
        // Scan down through the wrap, then freeze with en low
        add(1, 1, SD, 0, 0, 8'h02, 1, 0);
        add(1, 1, SD, 0, 0, 8'h01, 0, 1);
        add(1, 1, SD, 0, 0, 8'h80, 7, 1);
        for (int i = 0; i < 4; i++) add(1, 0, SD, 0, 0, 8'h00, 7, 0);
        add(1, 1, SD, 0, 0, 8'h40, 6, 1);
        // cnt reaches 1 under SCAN_UP div=3, then switch to SCAN_DOWN
        add(1, 1, SU, 0, 3, 8'h40, 6, 0);
        add(1, 1, SU, 0, 3, 8'h40, 6, 0);
        for (int i = 0; i < 4; i++) add(1, 1, SD, 0, 3, 8'h40, 6, 0);
        add(1, 1, SD, 0, 3, 8'h20, 5, 1);
        // SCAN_UP div=2 from 6: step every third cycle
        add(1, 1, D, 6, 2, 8'h40, 6, 0);
        add(1, 1, SU, 0, 2, 8'h40, 6, 0);
        add(1, 1, SU, 0, 2, 8'h40, 6, 0);
        add(1, 1, SU, 0, 2, 8'h40, 6, 0);
        add(1, 1, SU, 0, 2, 8'h80, 7, 1);
        add(1, 1, SU, 0, 2, 8'h80, 7, 0);
        add(1, 1, SU, 0, 2, 8'h80, 7, 0);
        add(1, 1, SU, 0, 2, 8'h01, 0, 1);
        add(1, 1, SU, 0, 2, 8'h01, 0, 0);
        add(1, 1, SU, 0, 2, 8'h01, 0, 0);
        add(1, 1, SU, 0, 2, 8'h02, 1, 1);
        // Bounce down from 7 to 4, reset mid-sweep, resume upward
        add(1, 1, D, 7, 0, 8'h80, 7, 0);
        add(1, 1, B, 0, 0, 8'h80, 7, 0);
        add(1, 1, B, 0, 0, 8'h40, 6, 1);
        add(1, 1, B, 0, 0, 8'h20, 5, 1);
        add(1, 1, B, 0, 0, 8'h10, 4, 1);
        add(0, 1, B, 0, 0, 8'h00, 0, 0);
        add(1, 1, B, 0, 0, 8'h01, 0, 0);
        add(1, 1, B, 0, 0, 8'h02, 1, 1);
        add(1, 1, B, 0, 0, 8'h04, 2, 1);
        add(1, 1, B, 0, 0, 8'h08, 3, 1);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst_n, tbl[i].en, tbl[i].mode, tbl[i].sel, tbl[i].div);
            check($sformatf("tbl[%0d]", i), tbl[i].y, tbl[i].idx, tbl[i].tick);
        end

        // Randomized run, including div rewrites below the running count
        rmode = B;
        rdiv  = 4'd1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 14) == 0) rmode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0)
                rdiv = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(0, 3));
            apply(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 9) != 0),
                  rmode, 3'($urandom_range(0, N - 1)), rdiv);
            check($sformatf("rand[%0d]", i),
                  m_en ? (N'(1) << m_idx) : N'(0), 3'(m_idx), m_tick);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/demux_scan.md
DEMUX_SCAN -- requirements
Module: demux_scan

Interface
REQ-001 Parameter SEL_W, default 3, meaning select/index width; output count N = 2**SEL_W; legal range 1..6.
REQ-002 Parameter DIV_W, default 24, meaning prescaler width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  output enable; 0 forces y to zero and freezes idx, dir and prescaler.
REQ-006 mode  input  2  operating mode: 00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 BOUNCE.
REQ-007 sel  input  SEL_W  index to decode in DIRECT mode; ignored in the other modes.
REQ-008 div  input  DIV_W  step period minus one, in clk cycles, for the scan modes.
REQ-009 y  output  N  registered one-hot line output, or all zeros.
REQ-010 idx  output  SEL_W  registered index of the currently active line.
REQ-011 tick  output  1  one-cycle pulse on every cycle in which a scan step is taken.

Function
REQ-012 Invariant on every cycle: y == 0 when the registered enable is 0, otherwise y == 1 << idx; y is never multi-hot.
REQ-013 DIRECT with en=1: idx <= sel and y <= 1<<sel; latency 1 cycle; tick stays 0; prescaler held at 0.
REQ-014 Prescaler (scan modes, en=1): cnt counts 0..div; when cnt == div, tick=1 for that cycle, cnt <= 0 and idx steps; div=0 gives a step every cycle.
REQ-015 SCAN_UP step: idx <= idx+1, wrapping from N-1 to 0.
REQ-016 SCAN_DOWN step: idx <= idx-1, wrapping from 0 to N-1.
REQ-017 BOUNCE step: the dir register selects the step; going up at idx==N-1, dir flips to down and idx <= N-2; going down at idx==0, dir flips to up and idx <= 1; otherwise idx moves one place in dir. The result is the sequence 0..N-1..0 with the end points visited once per sweep.
REQ-018 BOUNCE with SEL_W=1 alternates 0,1,0,1.
REQ-019 Any change of mode: cnt <= 0 that cycle; idx is kept, so a scan resumes from the current index; dir is kept unless the new mode is SCAN_UP (dir <= up) or SCAN_DOWN (dir <= down).
REQ-020 Writing div while scanning takes effect immediately; if cnt > new div, the next compare fails, cnt continues to wrap at DIV_W bits and reaches div again; no other correction is applied.
REQ-021 en falling: y <= 0 next cycle, and idx, dir and cnt hold; en rising resumes with the same idx and cnt values.
REQ-022 Simultaneous en=0 and mode change: the mode-change clearing of cnt still applies.

Reset
REQ-023 When rst_n=0 at a clock edge: idx=0, y=0, tick=0, cnt=0, dir=up, registered enable=0; this overrides all other inputs, including mid-scan.
REQ-024 The first edge with rst_n=1 evaluates inputs normally, so y is valid one cycle after reset is released.

Structure
REQ-025 Package demux_scan_pkg holds the mode encodings (MODE_DIRECT, MODE_SCAN_UP, MODE_SCAN_DOWN, MODE_BOUNCE) and the dir encoding (DIR_UP=0, DIR_DOWN=1).
REQ-026 One sub-module, tick_gen (DIV_W-bit prescaler with clear, hold and div inputs, producing tick), is instantiated once; the index/direction logic and the one-hot register stay in demux_scan.

Verification
REQ-027 Reset then DIRECT, en=1, sel=5 -> after 1 cycle y=8'b00100000, idx=5, tick=0; sel=0 -> y=8'b00000001 next cycle.
REQ-028 SCAN_UP, div=2, from idx=6 -> tick every 3rd cycle; idx 7,0,1; y follows; y is never multi-hot.
REQ-029 BOUNCE, div=0, from idx=0 -> idx sequence 1..7,6..0,1 on consecutive cycles, with tick=1 each cycle.
REQ-030 SCAN_DOWN, div=0, from idx=0 -> idx=7 after 1 cycle; drop en for 4 cycles -> y=0 and idx stays 7; raise en -> idx 6 next step.
REQ-031 Mid-scan with cnt=1 and div=3: switch to SCAN_DOWN -> cnt cleared; first tick occurs 4 cycles later and idx decrements by 1.
REQ-032 Assert rst_n=0 for one cycle during BOUNCE going down at idx=4 -> idx=0, y=0, dir=up; a following BOUNCE with div=0 yields idx 1,2,3.
